// File: rtl/my_nios1_pio_pkg.sv
// Shared constants for the debounced PIO input port: register map and
// edge-capture mode encodings.
package my_nios1_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE    = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    // Unknown mode values fall back to rising-edge capture.
    function automatic logic edge_hit(input int mode, input logic rise, input logic fall);
        case (mode)
            int'(EDGE_FALL): return fall;
            int'(EDGE_ANY):  return rise | fall;
            default:         return rise;
        endcase
    endfunction

endpackage

// File: rtl/my_nios1_pio_in_debounced_if.sv
// Avalon-MM slave bus bundle for the debounced PIO input port.
interface my_nios1_pio_in_debounced_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/my_nios1_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a hold-time filter that
// accepts a new level only after it has been stable for DEBOUNCE_CYCLES clocks.
module my_nios1_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic deb
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RESET_BIT;
            sync2 <= RESET_BIT;
            cnt   <= '0;
            deb   <= RESET_BIT;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            // Any return to the accepted level restarts the hold window.
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/my_nios1_pio_in_debounced.sv
// Debounced switch/button input port: per-bit filter, edge capture with
// write-one-to-clear, interrupt mask and registered level IRQ.
module my_nios1_pio_in_debounced
    import my_nios1_pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    my_nios1_pio_in_debounced_if.slave     bus,
    input  logic [WIDTH-1:0]               in_port,
    output logic                           irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        my_nios1_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .pin   (in_port[i]),
            .deb   (deb[i])
        );
        assign edge_pulse[i] = edge_hit(EDGE_MODE, rise[i], fall[i]);
    end

    assign rise         = deb & ~deb_d;
    assign fall         = ~deb & deb_d;
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:    rd_next = 32'(deb);
            ADDR_IRQMASK: rd_next = 32'(irq_mask);
            ADDR_EDGE:    rd_next = 32'(edge_capture);
            default:      rd_next = '0;
        endcase
    end

    // deb_d resets to the same value as the filter, so leaving reset is never an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d        <= RESET_VALUE;
            irq_mask     <= '0;
            edge_capture <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            deb_d <= deb;
            if (wr_en && bus.address == ADDR_IRQMASK) begin
                irq_mask <= wdata;
            end
            if (wr_en && bus.address == ADDR_EDGE) begin
                edge_capture <= (edge_capture & ~wdata) | edge_pulse;
            end else begin
                edge_capture <= edge_capture | edge_pulse;
            end
            bus.readdata <= rd_next;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_my_nios1_pio_in_debounced.sv
// Bench for the debounced PIO input: a rising-capture and a falling-capture
// instance share stimulus and are compared each cycle against a window model.
module tb_my_nios1_pio_in_debounced;

    localparam int         DC = 4;
    localparam logic [7:0] RV = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic        irq_r;
    logic        irq_f;
    logic        chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    my_nios1_pio_in_debounced_if bus_r ();
    my_nios1_pio_in_debounced_if bus_f ();

    assign bus_r.address    = address;
    assign bus_r.chipselect = chipselect;
    assign bus_r.write_n    = write_n;
    assign bus_r.writedata  = writedata;
    assign bus_f.address    = address;
    assign bus_f.chipselect = chipselect;
    assign bus_f.write_n    = write_n;
    assign bus_f.writedata  = writedata;

    my_nios1_pio_in_debounced #(
        .WIDTH(8), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0), .RESET_VALUE(RV)
    ) dut_r (
        .clk(clk), .reset(reset), .bus(bus_r), .in_port(in_port), .irq(irq_r)
    );

    my_nios1_pio_in_debounced #(
        .WIDTH(8), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(1), .RESET_VALUE(RV)
    ) dut_f (
        .clk(clk), .reset(reset), .bus(bus_f), .in_port(in_port), .irq(irq_f)
    );

    // Model: a bit is accepted once its synchronised samples have disagreed with
    // the accepted level for DC consecutive clocks. Index 0 of the model arrays is
    // the rising-capture instance, index 1 the falling-capture instance.
    logic [7:0]  pins [$];
    logic [7:0]  deb_m;
    logic [7:0]  deb_prev_m;
    logic [7:0]  nd;
    logic [7:0]  ev     [2];
    logic [7:0]  mask_m [2];
    logic [7:0]  cap_m  [2];
    logic [31:0] rd_exp [2];
    logic        irq_exp[2];
    logic        wr;
    logic        held;

    always @(posedge clk) begin
        if (reset) begin
            pins.delete();
            for (int j = 0; j <= DC; j++) pins.push_back(RV);
            deb_m      = RV;
            deb_prev_m = RV;
            for (int k = 0; k < 2; k++) begin
                mask_m[k]  = '0;
                cap_m[k]   = '0;
                rd_exp[k]  = '0;
                irq_exp[k] = 1'b0;
            end
        end else begin
            wr    = chipselect && !write_n;
            ev[0] = deb_m & ~deb_prev_m;
            ev[1] = ~deb_m & deb_prev_m;
            for (int k = 0; k < 2; k++) begin
                case (address)
                    2'd0:    rd_exp[k] = {24'h0, deb_m};
                    2'd2:    rd_exp[k] = {24'h0, mask_m[k]};
                    2'd3:    rd_exp[k] = {24'h0, cap_m[k]};
                    default: rd_exp[k] = '0;
                endcase
                irq_exp[k] = |(cap_m[k] & mask_m[k]);
                if (wr && address == 2'd3) cap_m[k] = cap_m[k] & ~writedata[7:0];
                cap_m[k] = cap_m[k] | ev[k];
                if (wr && address == 2'd2) mask_m[k] = writedata[7:0];
            end
            nd = deb_m;
            for (int b = 0; b < 8; b++) begin
                held = 1'b1;
                for (int j = 1; j <= DC; j++) if (pins[j][b] == deb_m[b]) held = 1'b0;
                if (held) nd[b] = pins[1][b];
            end
            deb_prev_m = deb_m;
            deb_m      = nd;
            pins.push_front(in_port);
            void'(pins.pop_back());
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rd_rise",  bus_r.readdata, rd_exp[0]);
            check("model_irq_rise", 32'(irq_r),     32'(irq_exp[0]));
            check("model_rd_fallm", bus_f.readdata, rd_exp[1]);
            check("model_irq_fallm", 32'(irq_f),    32'(irq_exp[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        ticks(2);
        chk_en = 1'b1;
        reset  = 1'b0;

        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            tick();
            check("reset_rd_r", bus_r.readdata, 32'h0);
            check("reset_rd_f", bus_f.readdata, 32'h0);
            check("reset_irq",  32'(irq_r | irq_f), 32'h0);
        end

        // Rising edge on bit 0: accepted DC+2 clocks after the pin moves.
        address = 2'd0;
        in_port = 8'h01;
        ticks(6);
        check("latency_pre",  bus_r.readdata, 32'h00);
        tick();
        check("latency_data", bus_r.readdata, 32'h01);
        address = 2'd3;
        tick();
        check("cap_rise_r", bus_r.readdata, 32'h01);
        check("cap_rise_f", bus_f.readdata, 32'h00);
        check("irq_unmasked", 32'(irq_r), 32'h0);

        // Three-clock glitch on bit 3 is shorter than the hold window.
        in_port = 8'h09;
        ticks(3);
        in_port = 8'h01;
        ticks(8);
        address = 2'd0;
        tick();
        check("glitch_data", bus_r.readdata, 32'h01);
        address = 2'd3;
        tick();
        check("glitch_cap", bus_r.readdata, 32'h01);

        // Four-clock pulse on bit 4 is just long enough to pass in both directions.
        in_port = 8'h11;
        ticks(4);
        in_port = 8'h01;
        ticks(12);
        tick();
        check("pulse_cap_r", bus_r.readdata, 32'h11);
        check("pulse_cap_f", bus_f.readdata, 32'h10);

        bus_write(2'd3, 32'hFF);
        check("rd_during_wr_r", bus_r.readdata, 32'h11);
        check("rd_during_wr_f", bus_f.readdata, 32'h10);
        tick();
        check("cleared_r", bus_r.readdata, 32'h00);
        check("cleared_f", bus_f.readdata, 32'h00);

        // Masked interrupt on bit 0.
        bus_write(2'd2, 32'h01);
        in_port = 8'h00;
        ticks(10);
        check("irq_fallmode_set", 32'(irq_f), 32'h1);
        check("irq_risemode_idle", 32'(irq_r), 32'h0);
        in_port = 8'h01;
        ticks(7);
        check("irq_pre", 32'(irq_r), 32'h0);
        tick();
        check("irq_set", 32'(irq_r), 32'h1);
        bus_write(2'd3, 32'h01);
        check("irq_hold_on_clr", 32'(irq_r), 32'h1);
        tick();
        check("irq_cleared", 32'(irq_r), 32'h0);

        // Edge on bit 2 in the same clock as a clear of bit 2: the edge wins.
        bus_write(2'd2, 32'h05);
        in_port = 8'h05;
        ticks(6);
        address    = 2'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h04;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        check("simul_rd_prewrite", bus_r.readdata, 32'h00);
        tick();
        check("simul_cap_r", bus_r.readdata, 32'h04);
        check("simul_cap_f", bus_f.readdata, 32'h00);
        check("simul_irq_r", 32'(irq_r), 32'h1);

        in_port = 8'h01;
        ticks(10);
        tick();
        check("fallmode_cap", bus_f.readdata, 32'h04);
        check("risemode_keep", bus_r.readdata, 32'h04);
        check("fallmode_irq", 32'(irq_f), 32'h1);

        // Reset pulse with bit 5's filter part-way through its window.
        in_port = 8'h21;
        ticks(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_rd_r", bus_r.readdata, 32'h0);
        check("midrst_irq",  32'(irq_r | irq_f), 32'h0);
        address = 2'd2;
        tick();
        check("midrst_mask", bus_r.readdata, 32'h0);
        address = 2'd0;
        ticks(5);
        check("restart_pre",  bus_r.readdata, 32'h00);
        tick();
        check("restart_data", bus_r.readdata, 32'h21);
        address = 2'd3;
        ticks(2);
        check("restart_cap_r", bus_r.readdata, 32'h21);
        check("restart_cap_f", bus_f.readdata, 32'h00);

        ticks(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
